// File: rtl/fanin_arbiter_if.sv
// Handshake bundle between NUM_IN producers, the fan-in arbiter and a single consumer.
// The slave modport is the arbiter's view; master is the producer/consumer side.
interface fanin_arbiter_if #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SRC_WIDTH  = 2
);
  logic [NUM_IN-1:0]            en;
  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_ready;
  logic                         out_valid;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [SRC_WIDTH-1:0]         out_src;
  logic                         out_ready;

  modport master (
    output en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/fanin_arbiter.sv
// Round-robin fan-in of NUM_IN valid/ready producers into a 2-entry {data, src} FIFO.
// in_ready depends only on registered state and producer inputs, never on out_ready.
module fanin_arbiter #(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SRC_WIDTH  = 2
) (
  input logic           clk,
  input logic           reset,
  fanin_arbiter_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [SRC_WIDTH-1:0]  src;
  } entry_t;

  entry_t [1:0]         mem_q, mem_d;
  entry_t               hold_q, hold_d;
  entry_t               head;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [SRC_WIDTH-1:0] prio_q, prio_d;

  logic [NUM_IN-1:0]    cand;
  logic [NUM_IN-1:0]    in_ready;
  logic [SRC_WIDTH-1:0] grant;
  logic [SRC_WIDTH-1:0] idx;
  logic                 found;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 out_valid;

  // First candidate at or after prio_q, wrapping at NUM_IN.
  always_comb begin
    cand  = bus.en & bus.in_valid;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = SRC_WIDTH'((32'(prio_q) + k) % NUM_IN);
      if (!found && cand[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    full      = (count_q == 2'd2);
    push      = found && !full && !reset;
    in_ready  = '0;
    if (push) begin
      in_ready[grant] = 1'b1;
    end
    head      = mem_q[rd_ptr_q];
    out_valid = (count_q != 2'd0) && !reset;
    pop       = out_valid && bus.out_ready;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    hold_d   = out_valid ? head : hold_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q].data = bus.in_data[grant*DATA_WIDTH +: DATA_WIDTH];
      mem_d[wr_ptr_q].src  = grant;
      wr_ptr_d             = ~wr_ptr_q;
      prio_d               = (32'(grant) == NUM_IN - 1) ? '0 : grant + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      hold_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      prio_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      prio_q   <= prio_d;
    end
  end

  // When empty, the last presented head is held rather than a stale slot.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = reset ? '0 : (out_valid ? head.data : hold_q.data);
  assign bus.out_src   = reset ? '0 : (out_valid ? head.src : hold_q.src);

endmodule

// File: tb/tb_fanin_arbiter.sv
// Directed and randomized checks of fanin_arbiter against a queue-based reference model.
module tb_fanin_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 2;

  logic clk;
  logic reset;

  fanin_arbiter_if #(.NUM_IN(N), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) bus ();

  fanin_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } ent_t;

  ent_t          q[$];
  int            prio;
  logic [DW-1:0] last_d;
  logic [SW-1:0] last_s;
  int            total;
  int            passed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected grant from the round-robin rule applied to the model state.
  function automatic logic [N-1:0] exp_ready();
    int p;
    if (reset || q.size() >= 2) return '0;
    for (int k = 0; k < int'(N); k++) begin
      p = (prio + k) % N;
      if (bus.en[p] && bus.in_valid[p]) return N'(1) << p;
    end
    return '0;
  endfunction

  task automatic tick();
    logic [N-1:0] er;
    ent_t         e;
    bit           do_pop;
    #1;
    er = exp_ready();
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    chk("out_valid", 32'(bus.out_valid), 32'(!reset && q.size() > 0));
    if (reset) begin
      chk("out_data", 32'(bus.out_data), 32'd0);
      chk("out_src", 32'(bus.out_src), 32'd0);
    end else if (q.size() > 0) begin
      chk("out_data", 32'(bus.out_data), 32'(q[0].d));
      chk("out_src", 32'(bus.out_src), 32'(q[0].s));
    end else begin
      chk("out_data_hold", 32'(bus.out_data), 32'(last_d));
      chk("out_src_hold", 32'(bus.out_src), 32'(last_s));
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      prio   = 0;
      last_d = '0;
      last_s = '0;
    end else begin
      do_pop = (q.size() > 0) && bus.out_ready;
      if (q.size() > 0) begin
        last_d = q[0].d;
        last_s = q[0].s;
      end
      if (do_pop) void'(q.pop_front());
      for (int p = 0; p < int'(N); p++) begin
        if (er[p]) begin
          e.d = bus.in_data[p*DW +: DW];
          e.s = SW'(p);
          q.push_back(e);
          prio = (p + 1) % N;
        end
      end
    end
    #1;
  endtask

  task automatic set_port(input int p, input logic [DW-1:0] d);
    bus.in_data[p*DW +: DW] = d;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    prio   = 0;
    last_d = '0;
    last_s = '0;
    reset         = 1'b1;
    bus.en        = 4'hF;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) set_port(i, DW'(16'h00A0 + i));

    // Reset held for two cycles with every port requesting.
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("post_reset_ready", 32'(bus.in_ready), 32'h1);
    chk("post_reset_valid", 32'(bus.out_valid), 32'h0);
    tick();

    // Fairness: all ports valid, consumer always ready.
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("fair_src", 32'(bus.out_src), 32'(i % 4));
      chk("fair_data", 32'(bus.out_data), 32'(16'h00A0 + (i % 4)));
      tick();
    end

    // Mask: only ports 1 and 3 may be granted.
    bus.en = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("mask_ready02", 32'(bus.in_ready & 4'b0101), 32'h0);
      tick();
    end

    // Drain, then backpressure on port 2.
    bus.en       = 4'hF;
    bus.in_valid = 4'h0;
    for (int i = 0; i < 3; i++) tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0100;
    set_port(2, 16'h1234);
    #1;
    chk("bp_ready0", 32'(bus.in_ready), 32'h4);
    tick();
    set_port(2, 16'h5678);
    #1;
    chk("bp_ready1", 32'(bus.in_ready), 32'h4);
    tick();
    #1;
    chk("bp_full", 32'(bus.in_ready), 32'h0);
    tick();
    tick();
    bus.in_valid  = 4'h0;
    bus.out_ready = 1'b1;
    #1;
    chk("bp_data0", 32'(bus.out_data), 32'h1234);
    chk("bp_src0", 32'(bus.out_src), 32'h2);
    tick();
    #1;
    chk("bp_data1", 32'(bus.out_data), 32'h5678);
    chk("bp_src1", 32'(bus.out_src), 32'h2);
    tick();
    tick();

    // One stored entry, then push and pop in the same cycle.
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0001;
    set_port(0, 16'h1111);
    tick();
    set_port(0, 16'h2222);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 4'h0;
    #1;
    chk("sim_valid", 32'(bus.out_valid), 32'h1);
    chk("sim_data", 32'(bus.out_data), 32'h2222);
    tick();
    #1;
    chk("sim_empty", 32'(bus.out_valid), 32'h0);
    tick();

    // Fill the FIFO, then reset it mid-operation.
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'hF;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    bus.in_valid  = 4'h0;
    bus.out_ready = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    for (int i = 0; i < 4; i++) tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      bus.en        = N'($urandom);
      bus.in_valid  = N'($urandom);
      bus.in_data   = (N*DW)'({$urandom, $urandom});
      bus.out_ready = ($urandom_range(0, 3) != 0);
      reset         = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
